divisor_secuencial_n_bits: RTL
==============================

# divisor_secuencial_N_bits

Multi-cycle unsigned restoring divider for the single-cycle processor's arithmetic datapath. It sits directly downstream of the N-bit subtractor: each iteration feeds a shifted partial remainder and the divisor into an (N+1)-bit subtractor instance, and consumes its difference and borrow output. The borrow output is the inverted adder carry, so borrow=1 means minuend < subtrahend. The divider computes one quotient bit per clock and presents quotient, remainder and status flags to the ALU result mux.

## Interface
- N, default 4: operand, quotient and remainder width. N ≥ 2.

Ports:
- clk, input, 1: single clock. All state changes on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request a division. Sampled only in IDLE.
- dividendo, input, N: unsigned dividend. Captured when start is accepted.
- divisor, input, N: unsigned divisor. Captured when start is accepted.
- cociente, output, N: registered quotient.
- residuo, output, N: registered remainder.
- listo, output, 1: one-cycle pulse marking new valid results.
- ocupado, output, 1: high while a division is in progress, CALC or DONE.
- div_cero, output, 1: registered flag. Set to 1 if the last completed division had divisor = 0.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Internal registers:
  - Q, N bits: shifts the dividend out and the quotient in.
  - R, N bits: partial remainder.
  - D, N bits: latched divisor.
  - cnt, ceil(log2(N+1)) bits: iteration counter.
- IDLE:
  - If start=1 and divisor≠0: Q←dividendo, R←0, D←divisor, cnt←0, go to CALC.
  - If start=1 and divisor=0: go straight to DONE, loading cociente←all ones, residuo←dividendo, div_cero←1.
  - If start=0: stay in IDLE. Outputs hold their values.
- CALC, one iteration per cycle:
  - P = {R, Q[N-1]}, N+1 bits.
  - (dif, borrow) = P − {0, D}, computed by the (N+1)-bit subtractor with ci=0.
  - If borrow=0: R←dif[N-1:0]. If borrow=1: R←P[N-1:0] (restore).
  - Q←{Q[N-2:0], ~borrow}; cnt←cnt+1.
  - On the iteration where cnt=N−1: write cociente←new Q, residuo←new R, div_cero←0, then go to DONE.
- DONE: listo=1 for exactly this cycle, then go to IDLE unconditionally.
- Arithmetic invariants on completion with D≠0:
  - dividendo = cociente·divisor + residuo.
  - residuo < divisor.
  - dif[N] is always 0 when borrow=0, so R never overflows N bits.
- start is ignored in CALC and DONE. No queuing, no error.
- Operand inputs may change freely after acceptance. Only the latched copies are used.
- cociente, residuo and div_cero change only on the edge entering DONE or on reset. They hold their values through IDLE and CALC.

## Timing
- Reset values: state=IDLE, cociente=0, residuo=0, div_cero=0, listo=0, ocupado=0; Q, R, D and cnt are cleared to 0.
- rst=1 in any state, including mid-CALC, aborts the division on that edge with no result written. rst has priority over start.
- Normal division, start accepted at edge k:
  - CALC occupies edges k+1 … k+N.
  - Results and DONE are registered at edge k+N. listo=1 during the cycle after edge k+N.
  - IDLE is reached at edge k+N+1. The earliest next accept is edge k+N+2.
  - Latency from start to listo is N+1 edges.
- Divide by zero: start accepted at edge k makes listo=1 and div_cero=1 during the cycle after edge k. IDLE is reached at edge k+1.
- ocupado=1 exactly in CALC and DONE.
- listo and ocupado are decoded from registered state only, with no combinational path from start.

## Test plan
- N=4, 13÷3, start for one cycle → after 5 edges: listo=1, cociente=4, residuo=1, div_cero=0, ocupado=1; next cycle listo=0, ocupado=0.
- N=4 corner operands: 15÷1 → q=15, r=0; 3÷7 → q=0, r=3; 0÷5 → q=0, r=0; 15÷15 → q=1, r=0.
- N=4, 9÷0 → after 1 edge: listo=1, div_cero=1, cociente=15, residuo=9. A following 8÷2 clears div_cero=0 and returns q=4, r=0.
- N=4, 13÷3 with start held high for 10 cycles and operands changed to 1÷1 on the cycle after accept → exactly one listo in the first N+2 cycles with q=4, r=1. Then 1÷1 is accepted in the next IDLE (start still held), giving q=1, r=0.
- N=4, start 12÷5, rst=1 at second CALC cycle → next cycle all outputs 0, state IDLE, no listo. Then 12÷5 → q=2, r=2.
- N=8, exhaustive random sweep of 200 pairs plus 255÷16 → q=15, r=15 with listo after 9 edges. Every result checked against dividend = q·d + r with r < d.

Source files
------------

// File: rtl/divisor_secuencial_n_bits.sv
// -----------------------------------------------------------------------------
// divisor_secuencial_n_bits
//
// Multi-cycle unsigned restoring divider. It produces one quotient bit per
// clock. Each iteration subtracts the latched divisor from the shifted partial
// remainder using an (N+1)-bit subtractor. The borrow of that subtraction
// decides whether the difference is kept or the old value is restored.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst        : synchronous, active-high reset (priority over start)
//   start      : request a division (sampled only in IDLE)
//   dividendo  : N-bit unsigned dividend, captured on accept
//   divisor    : N-bit unsigned divisor, captured on accept
//   cociente   : registered quotient
//   residuo    : registered remainder
//   listo      : one-cycle pulse while in DONE (new results valid)
//   ocupado    : high in CALC and DONE
//   div_cero   : registered flag, last completed division had divisor = 0
// -----------------------------------------------------------------------------
module divisor_secuencial_n_bits #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         listo,
    output logic         ocupado,
    output logic         div_cero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  q_q, q_d;        // dividend shifts out, quotient shifts in
    logic [N-1:0]  r_q, r_d;        // partial remainder
    logic [N-1:0]  d_q, d_d;        // latched divisor
    logic [CW-1:0] cnt_q, cnt_d;    // iteration counter
    logic [N-1:0]  cociente_q, cociente_d;
    logic [N-1:0]  residuo_q, residuo_d;
    logic          div_cero_q, div_cero_d;

    // One restoring step: P = {R, Q msb}; P - {0, D} on N+1 bits, with the
    // extra top bit of the extended result acting as the borrow.
    logic [N:0]    p;
    logic [N+1:0]  diff_ext;
    logic          borrow;
    logic [N-1:0]  q_next;
    logic [N-1:0]  r_next;
    logic          unused_dif_msb;

    assign p        = {r_q, q_q[N-1]};
    assign diff_ext = {1'b0, p} - {2'b00, d_q};
    assign borrow   = diff_ext[N+1];
    // dif[N] is always 0 when no borrow occurs, so R fits in N bits.
    assign unused_dif_msb = diff_ext[N];
    assign r_next   = borrow ? p[N-1:0] : diff_ext[N-1:0];
    assign q_next   = {q_q[N-2:0], ~borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q_q        <= '0;
            r_q        <= '0;
            d_q        <= '0;
            cnt_q      <= '0;
            cociente_q <= '0;
            residuo_q  <= '0;
            div_cero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_q        <= q_d;
            r_q        <= r_d;
            d_q        <= d_d;
            cnt_q      <= cnt_d;
            cociente_q <= cociente_d;
            residuo_q  <= residuo_d;
            div_cero_q <= div_cero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_d        = q_q;
        r_d        = r_q;
        d_d        = d_q;
        cnt_d      = cnt_q;
        cociente_d = cociente_q;
        residuo_d  = residuo_q;
        div_cero_d = div_cero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        q_d     = dividendo;
                        r_d     = '0;
                        d_d     = divisor;
                        cnt_d   = '0;
                        state_d = CALC;
                    end else begin
                        // Divide by zero: report immediately, no iterations.
                        cociente_d = '1;
                        residuo_d  = dividendo;
                        div_cero_d = 1'b1;
                        state_d    = DONE;
                    end
                end
            end
            CALC: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cociente_d = q_next;
                    residuo_d  = r_next;
                    div_cero_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cociente = cociente_q;
    assign residuo  = residuo_q;
    assign div_cero = div_cero_q;
    assign listo    = (state_q == DONE);
    assign ocupado  = (state_q != IDLE);

endmodule
